sram_sdi_arbiter: RTL and testbench
===================================

SRAM_SDI_ARBITER -- requirements
Module: sram_sdi_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  in  1  system clock (16 MHz domain).
REQ-002 rst_n  in  1  reset; asynchronous and active-low.
REQ-003 a_req, a_we  in  1 each  port A (CPU) request and write-enable.
REQ-004 a_addr  in  17  port A byte address; a_wdata  in  8  port A write data.
REQ-005 a_ack  out  1  port A completion pulse; a_rdata  out  8  port A read data.
REQ-006 b_req, b_we, b_addr[16:0], b_wdata[7:0], b_ack, b_rdata[7:0]: port B (host loader), same directions and meanings as port A.
REQ-007 ready  out  1  high once SDI-mode init is complete.
REQ-008 sram_cs  out  1  SRAM chip select, active-low; sram_sck  out  1  serial clock.
REQ-009 sram_d_out  out  2, sram_d_oe  out  2 (per-bit drive enable), sram_d_in  in  2: SDI data lines, bit 1 = SIO1, bit 0 = SIO0.

Function
REQ-010 sram_sck period SHALL be 2 clk: low cycle, then high cycle; sram_d_out changes only on entry to the low cycle; sram_d_in is sampled on the clk edge ending the high cycle.
REQ-011 Bits SHALL be shifted MSB first: 1 bit per SCK on SIO0 in SPI mode, 2 bits per SCK (upper bit on SIO1) in SDI mode.
REQ-012 States: INIT, IDLE, CMD, ADDR, DUMMY, DATA, DONE.
REQ-013 INIT: cs low, sram_d_oe=01, send 0x3B (EDIO) in SPI mode over 8 SCK; then cs high for 2 clk, then ready=1 and go to IDLE.
REQ-014 While ready=0, requests SHALL be ignored and no ack issued.
REQ-015 IDLE with ready=1 and a request present: latch winner's addr/we/wdata and port id; go to CMD next cycle with cs low.
REQ-016 Arbitration SHALL be round-robin: one requester wins; both requesting → the port not granted last wins; after reset, A is treated as last-granted-B (A wins first tie).
REQ-017 CMD: 4 SCK sending 0x03 (read) or 0x02 (write), oe=11.
REQ-018 ADDR: 12 SCK sending {7'b0, addr[16:0]} (24 bits), oe=11.
REQ-019 Read: DUMMY 4 SCK with oe=00, then DATA 4 SCK with oe=00, capturing 8 bits from sram_d_in.
REQ-020 Write: DATA 4 SCK sending wdata, oe=11; no DUMMY.
REQ-021 DONE: cs high, sck low, oe=00, ack pulse on the granted port for exactly 1 clk; on read, that port's rdata updates in the same cycle.
REQ-022 Read SHALL take 48 clk from first cs-low cycle to DONE; write 40 clk.
REQ-023 After DONE the block SHALL spend at least 1 clk in IDLE; cs high for at least 2 clk between transactions.
REQ-024 Requester SHALL hold req, we, addr, wdata stable until ack; the block samples them only at grant.
REQ-025 Requester deasserting req before ack: transaction still completes and acks; ack is not suppressed.
REQ-026 A request held high in the cycle after its ack is treated as a new request.
REQ-027 rdata of each port SHALL hold its last read value; writes and the other port's traffic do not change it.
REQ-028 sram_sck SHALL be low whenever cs is high.

Reset
REQ-029 On rst_n low, asynchronously: sram_cs=1, sram_sck=0, sram_d_out=00, sram_d_oe=00, a_ack=b_ack=0, a_rdata=b_rdata=0x00, ready=0, state=INIT pending, round-robin pointer reset.
REQ-030 On rst_n release, INIT SHALL start on the next clk; a reset during any transaction aborts it without ack and repeats INIT.

Verification
REQ-031 Init: release reset → 8 SCK on SIO0 carrying 0x3B with cs low, oe=01, then ready=1.
REQ-032 Port A write 0x5A to 0x1ABCD → SIO lines carry 0x02, 0x01ABCD, 0x5A; a_ack 1 clk, 40 clk after cs low.
REQ-033 Port B read 0x00010, model returns 0xC3 → b_ack after 48 clk, b_rdata=0xC3, a_rdata unchanged.
REQ-034 A and B request on same cycle, held → A served, then B, then A; ack order A,B,A with cs high ≥2 clk between.
REQ-035 Reset asserted mid-ADDR → cs high, oe=00 immediately, no ack, INIT resends 0x3B.
REQ-036 Request issued before ready=1 → no ack until after init; served afterward with correct data.

Source files
------------

// File: rtl/sram_sdi_arbiter.sv
// Two-port byte arbiter for a serial SRAM in SDI (2-bit) mode.
// Switches the SRAM to EDIO at reset, then serves ports round-robin.
module sram_sdi_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [16:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [16:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic        ready,
  output logic        sram_cs,
  output logic        sram_sck,
  output logic [1:0]  sram_d_out,
  output logic [1:0]  sram_d_oe,
  input  logic [1:0]  sram_d_in
);

  typedef enum logic [2:0] {
    INIT, IDLE, CMD, ADDR, DUMMY, DATA, DONE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [39:0] sh, sh_n;
  logic [7:0]  rx, rx_n;
  logic [7:0]  cmd;
  logic [7:0]  a_rdata_n, b_rdata_n;
  logic [1:0]  d_out_n, oe_n;
  logic        we_l, we_n;
  logic        gnt_b, gnt_n;
  logic        last_b, last_n;
  logic        ready_n, cs_n, sck_n;
  logic        a_ack_n, b_ack_n;
  logic        spi, act, drv;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 5'd1;
    sh_n      = sh;
    rx_n      = rx;
    we_n      = we_l;
    gnt_n     = gnt_b;
    last_n    = last_b;
    ready_n   = ready;
    a_rdata_n = a_rdata;
    b_rdata_n = b_rdata;
    cmd       = 8'h03;
    unique case (state)
      INIT: begin
        if (cnt == 5'd17) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (ready && (a_req || b_req)) begin
          gnt_n   = b_req && (!a_req || !last_b);
          last_n  = gnt_n;
          we_n    = gnt_n ? b_we : a_we;
          cmd     = we_n ? 8'h02 : 8'h03;
          sh_n    = gnt_n ? {cmd, 7'd0, b_addr, b_wdata}
                          : {cmd, 7'd0, a_addr, a_wdata};
          state_n = CMD;
        end
      end
      CMD: begin
        if (cnt == 5'd7) begin
          state_n = ADDR;
          cnt_n   = '0;
        end
      end
      ADDR: begin
        if (cnt == 5'd23) begin
          state_n = we_l ? DATA : DUMMY;
          cnt_n   = '0;
        end
      end
      DUMMY: begin
        if (cnt == 5'd7) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (cnt[0] && !we_l)
          rx_n = {rx[5:0], sram_d_in};
        if (cnt == 5'd7) begin
          state_n = DONE;
          cnt_n   = '0;
          if (!we_l && gnt_b)
            b_rdata_n = rx_n;
          if (!we_l && !gnt_b)
            a_rdata_n = rx_n;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = INIT;
    endcase

    // Pins are registered from the next state; odd counts are SCK-high.
    spi     = state_n == INIT && cnt_n < 5'd16;
    act     = spi || state_n inside {CMD, ADDR, DUMMY, DATA};
    drv     = state_n inside {CMD, ADDR} || (state_n == DATA && we_n);
    cs_n    = !act;
    sck_n   = act && cnt_n[0];
    oe_n    = spi ? 2'b01 : (drv ? 2'b11 : 2'b00);
    a_ack_n = state_n == DONE && !gnt_n;
    b_ack_n = state_n == DONE && gnt_n;
    d_out_n = sram_d_out;
    if (act && !cnt_n[0]) begin
      if (spi) begin
        d_out_n = {1'b0, sh_n[39]};
        sh_n    = {sh_n[38:0], 1'b0};
      end else if (drv) begin
        d_out_n = sh_n[39:38];
        sh_n    = {sh_n[37:0], 2'b00};
      end else begin
        d_out_n = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= 5'h1f;
      sh         <= {8'h3B, 32'd0};
      rx         <= '0;
      we_l       <= 1'b0;
      gnt_b      <= 1'b0;
      last_b     <= 1'b1;
      ready      <= 1'b0;
      sram_cs    <= 1'b1;
      sram_sck   <= 1'b0;
      sram_d_out <= 2'b00;
      sram_d_oe  <= 2'b00;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      rx         <= rx_n;
      we_l       <= we_n;
      gnt_b      <= gnt_n;
      last_b     <= last_n;
      ready      <= ready_n;
      sram_cs    <= cs_n;
      sram_sck   <= sck_n;
      sram_d_out <= d_out_n;
      sram_d_oe  <= oe_n;
      a_ack      <= a_ack_n;
      b_ack      <= b_ack_n;
      a_rdata    <= a_rdata_n;
      b_rdata    <= b_rdata_n;
    end
  end

endmodule

// File: tb/tb_sram_sdi_arbiter.sv
// Directed bench for sram_sdi_arbiter with a bus monitor
// that decodes SIO frames and returns read bytes.
`timescale 1ns/1ps
module tb_sram_sdi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [16:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [16:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic        ready;
  logic        sram_cs, sram_sck;
  logic [1:0]  sram_d_out, sram_d_oe;
  logic [1:0]  sram_d_in = 2'b00;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rd_byte = 8'h00;
  logic [7:0]  tmp;
  logic [63:0] cap = '0, frame = '0;
  int nb = 0, fnb = 0, low = 0, flow = 0;
  int hi = 0, gap = 0, k = 0, sck_err = 0;
  logic prev_cs = 1'b1;

  always #5 clk = ~clk;

  sram_sdi_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .ready      (ready),
    .sram_cs    (sram_cs),
    .sram_sck   (sram_sck),
    .sram_d_out (sram_d_out),
    .sram_d_oe  (sram_d_oe),
    .sram_d_in  (sram_d_in)
  );

  // Bus monitor and SRAM read model; data bits on SCK-high cycles.
  always @(negedge clk) begin
    if (sram_cs) begin
      if (sram_sck) sck_err++;
      if (!prev_cs) begin
        frame = cap;
        fnb   = nb;
        flow  = low;
        hi    = 0;
      end
      hi++;
      cap = '0;
      nb  = 0;
      low = 0;
      k   = 0;
    end else begin
      if (prev_cs) gap = hi;
      low++;
      if (sram_sck) begin
        if (sram_d_oe == 2'b01) begin
          cap = {cap[62:0], sram_d_out[0]};
          nb  = nb + 1;
        end else if (sram_d_oe == 2'b11) begin
          cap = {cap[61:0], sram_d_out};
          nb  = nb + 2;
        end
        if (k >= 20 && k <= 23) begin
          tmp = rd_byte >> (2 * (23 - k));
          sram_d_in = tmp[1:0];
        end
        k++;
      end
    end
    prev_cs = sram_cs;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_cs, sram_sck, sram_d_out, sram_d_oe} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_pins got=%b exp=100000",
               {sram_cs, sram_sck, sram_d_out, sram_d_oe});
    end
    checks++;
    if ({a_ack, b_ack, ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000", {a_ack, b_ack, ready});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0000", {a_rdata, b_rdata});
    end
  endtask

  task automatic test_init_pending();
    int c;
    bit early;
    a_we    = 1'b0;
    a_addr  = 17'h00055;
    rd_byte = 8'hA7;
    a_req   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    c = 0;
    while (!ready && c < 60) begin
      @(negedge clk);
      if (a_ack || b_ack) early = 1'b1;
      c++;
    end
    #1;
    checks++;
    if (c !== 19) begin
      failures++;
      $display("FAIL init_ready_cycles got=%0d exp=19", c);
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL init_early_ack got=1 exp=0");
    end
    checks++;
    if (fnb !== 8 || frame[7:0] !== 8'h3B) begin
      failures++;
      $display("FAIL init_frame got=%0d/%h exp=8/3b", fnb, frame[7:0]);
    end
    c = 0;
    while (!a_ack && c < 120) begin
      @(negedge clk);
      c++;
    end
    a_req = 1'b0;
    #1;
    checks++;
    if (!a_ack) begin
      failures++;
      $display("FAIL pend_ack_timeout got=0 exp=1");
    end
    checks++;
    if (flow !== 48 || fnb !== 32 || frame[31:0] !== 32'h03000055) begin
      failures++;
      $display("FAIL pend_frame got=%0d/%0d/%h exp=48/32/03000055",
               flow, fnb, frame[31:0]);
    end
    checks++;
    if (a_rdata !== 8'hA7 || b_ack !== 1'b0) begin
      failures++;
      $display("FAIL pend_rdata got=%h/%b exp=a7/0", a_rdata, b_ack);
    end
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0) begin
      failures++;
      $display("FAIL pend_ack_width got=1 exp=0");
    end
  endtask

  task automatic test_write_a();
    int c;
    a_we    = 1'b1;
    a_addr  = 17'h1ABCD;
    a_wdata = 8'h5A;
    a_req   = 1'b1;
    c = 0;
    while (!a_ack && c < 120) begin
      @(negedge clk);
      c++;
    end
    a_req = 1'b0;
    #1;
    checks++;
    if (!a_ack) begin
      failures++;
      $display("FAIL wr_ack_timeout got=0 exp=1");
    end
    checks++;
    if (flow !== 40 || fnb !== 40) begin
      failures++;
      $display("FAIL wr_len got=%0d/%0d exp=40/40", flow, fnb);
    end
    checks++;
    if (frame[39:0] !== 40'h0201ABCD5A) begin
      failures++;
      $display("FAIL wr_frame got=%h exp=0201abcd5a", frame[39:0]);
    end
    checks++;
    if (b_ack !== 1'b0 || a_rdata !== 8'hA7) begin
      failures++;
      $display("FAIL wr_side got=%b/%h exp=0/a7", b_ack, a_rdata);
    end
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack_width got=1 exp=0");
    end
  endtask

  task automatic test_read_b();
    int c;
    rd_byte = 8'hC3;
    b_we    = 1'b0;
    b_addr  = 17'h00010;
    b_req   = 1'b1;
    c = 0;
    while (sram_cs && c < 20) begin
      @(negedge clk);
      c++;
    end
    b_req = 1'b0;
    c = 0;
    while (!b_ack && c < 120) begin
      @(negedge clk);
      c++;
    end
    #1;
    checks++;
    if (!b_ack) begin
      failures++;
      $display("FAIL rd_ack_timeout got=0 exp=1");
    end
    checks++;
    if (flow !== 48 || fnb !== 32 || frame[31:0] !== 32'h03000010) begin
      failures++;
      $display("FAIL rd_frame got=%0d/%0d/%h exp=48/32/03000010",
               flow, fnb, frame[31:0]);
    end
    checks++;
    if (b_rdata !== 8'hC3 || a_rdata !== 8'hA7 || a_ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_data got=%h/%h/%b exp=c3/a7/0",
               b_rdata, a_rdata, a_ack);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit exp_b;
    a_we = 1'b1; a_addr = 17'h00AAA; a_wdata = 8'h11;
    b_we = 1'b1; b_addr = 17'h0BBBB; b_wdata = 8'h22;
    @(negedge clk);
    a_req = 1'b1;
    b_req = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 3; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        exp_b = (n == 1);
        if (n == 2) begin
          a_req = 1'b0;
          b_req = 1'b0;
        end
        #1;
        checks++;
        if ({a_ack, b_ack} !== (exp_b ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL rr_order%0d got=%b exp=%b", n,
                   {a_ack, b_ack}, exp_b ? 2'b01 : 2'b10);
        end
        checks++;
        if (frame[39:0] !== (exp_b ? 40'h0200BBBB22 : 40'h02000AAA11)) begin
          failures++;
          $display("FAIL rr_frame%0d got=%h", n, frame[39:0]);
        end
        if (n > 0) begin
          checks++;
          if (gap < 2) begin
            failures++;
            $display("FAIL rr_gap%0d got=%0d exp>=2", n, gap);
          end
        end
        n++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL rr_timeout got=%0d exp=3", n);
    end
    checks++;
    if (a_rdata !== 8'hA7 || b_rdata !== 8'hC3) begin
      failures++;
      $display("FAIL rr_rdata got=%h/%h exp=a7/c3", a_rdata, b_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bit early;
    a_we    = 1'b1;
    a_addr  = 17'h12345;
    a_wdata = 8'h99;
    @(negedge clk);
    a_req = 1'b1;
    c = 0;
    while (sram_cs && c < 20) begin
      @(negedge clk);
      c++;
    end
    repeat (14) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_cs, sram_sck, sram_d_out, sram_d_oe} !== 6'b100000) begin
      failures++;
      $display("FAIL mid_pins got=%b exp=100000",
               {sram_cs, sram_sck, sram_d_out, sram_d_oe});
    end
    checks++;
    if ({a_ack, b_ack, ready} !== 3'b000 || a_rdata !== 8'h00) begin
      failures++;
      $display("FAIL mid_ctl got=%b/%h exp=000/00",
               {a_ack, b_ack, ready}, a_rdata);
    end
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    c = 0;
    while (!ready && c < 60) begin
      @(negedge clk);
      if (a_ack || b_ack) early = 1'b1;
      c++;
    end
    #1;
    checks++;
    if (!ready || early) begin
      failures++;
      $display("FAIL mid_reinit got=%b/%b exp=1/0", ready, early);
    end
    checks++;
    if (fnb !== 8 || frame[7:0] !== 8'h3B) begin
      failures++;
      $display("FAIL mid_frame got=%0d/%h exp=8/3b", fnb, frame[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_init_pending();
    test_write_a();
    test_read_b();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sck_err != 0) begin
      failures++;
      $display("FAIL sck_idle got=%0d exp=0", sck_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
